// File: rtl/vu_commit_retire_ctrl.sv
// rtl/vu_commit_retire_ctrl.sv - commit grant, in-order retire check, issue credits and flush drain
// Consumes the vector unit's aggregated commits and hands retired issue numbers to the scalar side.
module vu_commit_retire_ctrl #(
   parameter int WIDTH_ISSUE  = 7,
   parameter int MAX_INFLIGHT = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   I_Issue_Req,
   input  logic [WIDTH_ISSUE-1:0] I_Issue_No,
   output logic                   O_Issue_Stall,
   input  logic                   I_Commit_Req,
   input  logic [WIDTH_ISSUE-1:0] I_Commit_No,
   output logic                   O_Commit_Grant,
   output logic                   O_Retire_Valid,
   output logic [WIDTH_ISSUE-1:0] O_Retire_No,
   input  logic                   I_Retire_Ready,
   input  logic                   I_Flush,
   output logic                   O_Empty,
   output logic                   O_Err_Order
);

   localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
   localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_INFLIGHT);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_INFLIGHT - 1);

   typedef enum logic {ST_RUN, ST_DRAIN} state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [WIDTH_ISSUE-1:0] fifo_q [MAX_INFLIGHT];
   logic [WIDTH_ISSUE-1:0] fifo_d [MAX_INFLIGHT];
   logic                   retire_valid_q, retire_valid_d;
   logic [WIDTH_ISSUE-1:0] retire_no_q, retire_no_d;
   logic                   err_order_q, err_order_d;

   logic issue_acc;
   logic slot_free;
   logic grant;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      O_Issue_Stall  = (cnt_q == CNT_MAX) | (state_q == ST_DRAIN);
      slot_free      = ~retire_valid_q | I_Retire_Ready;
      grant          = I_Commit_Req & slot_free & (cnt_q != '0);
      issue_acc      = I_Issue_Req & ~O_Issue_Stall;
      O_Commit_Grant = grant;
      O_Retire_Valid = retire_valid_q;
      O_Retire_No    = retire_no_q;
      O_Empty        = (cnt_q == '0) & ~retire_valid_q;
      O_Err_Order    = err_order_q;
   end

   always_comb begin
      fifo_d         = fifo_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      cnt_d          = cnt_q;
      retire_valid_d = retire_valid_q;
      retire_no_d    = retire_no_q;
      err_order_d    = err_order_q;
      state_d        = state_q;

      if (issue_acc) begin
         fifo_d[wr_ptr_q] = I_Issue_No;
         wr_ptr_d         = ptr_inc(wr_ptr_q);
      end
      if (grant) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end

      case ({issue_acc, grant})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase

      // A granted commit always retires, even when it flags an ordering error.
      if (grant) begin
         retire_valid_d = 1'b1;
         retire_no_d    = I_Commit_No;
      end else if (retire_valid_q & I_Retire_Ready) begin
         retire_valid_d = 1'b0;
      end

      if (grant && (I_Commit_No != fifo_q[rd_ptr_q])) begin
         err_order_d = 1'b1;
      end
      if (I_Commit_Req && (cnt_q == '0)) begin
         err_order_d = 1'b1;
      end

      case (state_q)
         ST_RUN: begin
            if (I_Flush) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if ((cnt_q == '0) && !retire_valid_q) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= ST_RUN;
         cnt_q          <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         retire_valid_q <= 1'b0;
         retire_no_q    <= '0;
         err_order_q    <= 1'b0;
         for (int i = 0; i < MAX_INFLIGHT; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         retire_valid_q <= retire_valid_d;
         retire_no_q    <= retire_no_d;
         err_order_q    <= err_order_d;
         fifo_q         <= fifo_d;
      end
   end

endmodule
